// File: rtl/waveform_dm_cmd_ctrl.sv
// waveform_dm_cmd_ctrl: DataMover S2MM/MM2S command issuer and status checker; define WAVEFORM_DM_LOOP_EN for MM2S looped playback via rd_loop
module waveform_dm_cmd_ch #(
  parameter int STS_TIMEOUT = 4096,
  parameter int TO_W = 16
) (
  input  logic        clk_in1,
  input  logic        aresetn,
  input  logic        req,
  input  logic        loop,
  input  logic [31:0] addr,
  input  logic [22:0] btt,
  input  logic        err_clr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout,
  output logic [71:0] cmd_tdata,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  input  logic [7:0]  sts_tdata,
  input  logic        sts_tvalid,
  output logic        sts_tready
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT_STS} state_t;
  state_t state;
  logic [31:0] a;
  logic [22:0] b;
  logic [3:0] tag, issued;
  logic [TO_W-1:0] cnt;
  logic loop_on, ok, to_hit;
  assign ok = sts_tdata[7] & ~|sts_tdata[6:4] & (sts_tdata[3:0] == issued);
  assign to_hit = (STS_TIMEOUT != 0) && (cnt == TO_W'(STS_TIMEOUT - 1));
  assign cmd_tdata = {4'd0, tag, a, 1'b0, 1'b1, 6'd0, 1'b1, b};
  always_ff @(posedge clk_in1) begin
    if (!aresetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      timeout <= 1'b0;
      cmd_tvalid <= 1'b0;
      sts_tready <= 1'b0;
      tag <= 4'd0;
      issued <= 4'd0;
      cnt <= '0;
      a <= '0;
      b <= '0;
      loop_on <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_clr) begin
        err <= 1'b0;
        timeout <= 1'b0;
      end
      case (state)
        IDLE: if (req) begin
          if (btt != 23'd0) begin
            a <= addr;
            b <= btt;
            loop_on <= loop;
            busy <= 1'b1;
            cmd_tvalid <= 1'b1;
            state <= CMD;
          end else begin
            done <= 1'b1;
            err <= 1'b1;
          end
        end
        CMD: if (cmd_tready) begin
          cmd_tvalid <= 1'b0;
          issued <= tag;
          tag <= tag + 4'd1;
          cnt <= '0;
          sts_tready <= 1'b1;
          state <= WAIT_STS;
        end
        WAIT_STS: if (sts_tvalid) begin
          done <= 1'b1;
          sts_tready <= 1'b0;
          if (!ok) err <= 1'b1;
          if (ok && loop_on && loop) begin
            cmd_tvalid <= 1'b1;
            state <= CMD;
          end else begin
            busy <= 1'b0;
            state <= IDLE;
          end
        end else if (to_hit) begin
          done <= 1'b1;
          err <= 1'b1;
          timeout <= 1'b1;
          sts_tready <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + TO_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module waveform_dm_cmd_ctrl #(
  parameter int STS_TIMEOUT = 4096,
  parameter int TO_W = 16
) (
  input  logic        clk_in1,
  input  logic        aresetn,
`ifdef WAVEFORM_DM_LOOP_EN
  input  logic        rd_loop,
`endif
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [22:0] wr_btt,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic [22:0] rd_btt,
  output logic        wr_busy,
  output logic        rd_busy,
  output logic        wr_done,
  output logic        rd_done,
  output logic        wr_err,
  output logic        rd_err,
  output logic        wr_timeout,
  output logic        rd_timeout,
  input  logic        err_clr,
  output logic [71:0] M_AXIS_S2MM_CMD_tdata,
  output logic        M_AXIS_S2MM_CMD_tvalid,
  input  logic        M_AXIS_S2MM_CMD_tready,
  output logic [71:0] M_AXIS_MM2S_CMD_tdata,
  output logic        M_AXIS_MM2S_CMD_tvalid,
  input  logic        M_AXIS_MM2S_CMD_tready,
  input  logic [7:0]  S_AXIS_S2MM_STS_tdata,
  input  logic        S_AXIS_S2MM_STS_tvalid,
  output logic        S_AXIS_S2MM_STS_tready,
  input  logic [7:0]  S_AXIS_MM2S_STS_tdata,
  input  logic        S_AXIS_MM2S_STS_tvalid,
  output logic        S_AXIS_MM2S_STS_tready
);
  logic rd_loop_on;
`ifdef WAVEFORM_DM_LOOP_EN
  assign rd_loop_on = rd_loop;
`else
  assign rd_loop_on = 1'b0;
`endif
  waveform_dm_cmd_ch #(.STS_TIMEOUT(STS_TIMEOUT), .TO_W(TO_W)) u_s2mm (
    .clk_in1(clk_in1), .aresetn(aresetn), .req(wr_req), .loop(1'b0),
    .addr(wr_addr), .btt(wr_btt), .err_clr(err_clr),
    .busy(wr_busy), .done(wr_done), .err(wr_err), .timeout(wr_timeout),
    .cmd_tdata(M_AXIS_S2MM_CMD_tdata), .cmd_tvalid(M_AXIS_S2MM_CMD_tvalid),
    .cmd_tready(M_AXIS_S2MM_CMD_tready), .sts_tdata(S_AXIS_S2MM_STS_tdata),
    .sts_tvalid(S_AXIS_S2MM_STS_tvalid), .sts_tready(S_AXIS_S2MM_STS_tready)
  );
  waveform_dm_cmd_ch #(.STS_TIMEOUT(STS_TIMEOUT), .TO_W(TO_W)) u_mm2s (
    .clk_in1(clk_in1), .aresetn(aresetn), .req(rd_req), .loop(rd_loop_on),
    .addr(rd_addr), .btt(rd_btt), .err_clr(err_clr),
    .busy(rd_busy), .done(rd_done), .err(rd_err), .timeout(rd_timeout),
    .cmd_tdata(M_AXIS_MM2S_CMD_tdata), .cmd_tvalid(M_AXIS_MM2S_CMD_tvalid),
    .cmd_tready(M_AXIS_MM2S_CMD_tready), .sts_tdata(S_AXIS_MM2S_STS_tdata),
    .sts_tvalid(S_AXIS_MM2S_STS_tvalid), .sts_tready(S_AXIS_MM2S_STS_tready)
  );
endmodule

// File: tb/tb_waveform_dm_cmd_ctrl.sv
// tb_waveform_dm_cmd_ctrl: vector, directed and random checks of the DataMover command controller
module tb_waveform_dm_cmd_ctrl;
  logic clk = 1'b0, aresetn = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req = '0, cready = '0, svalid = '0;
  logic [1:0] busy, done, err, tmo, cvalid, sready;
  logic [1:0][31:0] addr = '0;
  logic [1:0][22:0] btt = '0;
  logic [1:0][7:0] sdata = '0;
  logic [1:0][71:0] cdata;
`ifdef WAVEFORM_DM_LOOP_EN
  logic rd_loop = 1'b0;
`endif
  int n_cmp = 0, n_fail = 0;
  int tag_m[2] = '{0, 0};

  waveform_dm_cmd_ctrl #(.STS_TIMEOUT(16), .TO_W(16)) dut (
    .clk_in1(clk), .aresetn(aresetn),
`ifdef WAVEFORM_DM_LOOP_EN
    .rd_loop(rd_loop),
`endif
    .wr_req(req[0]), .wr_addr(addr[0]), .wr_btt(btt[0]),
    .rd_req(req[1]), .rd_addr(addr[1]), .rd_btt(btt[1]),
    .wr_busy(busy[0]), .rd_busy(busy[1]), .wr_done(done[0]), .rd_done(done[1]),
    .wr_err(err[0]), .rd_err(err[1]), .wr_timeout(tmo[0]), .rd_timeout(tmo[1]),
    .err_clr(clr),
    .M_AXIS_S2MM_CMD_tdata(cdata[0]), .M_AXIS_S2MM_CMD_tvalid(cvalid[0]), .M_AXIS_S2MM_CMD_tready(cready[0]),
    .M_AXIS_MM2S_CMD_tdata(cdata[1]), .M_AXIS_MM2S_CMD_tvalid(cvalid[1]), .M_AXIS_MM2S_CMD_tready(cready[1]),
    .S_AXIS_S2MM_STS_tdata(sdata[0]), .S_AXIS_S2MM_STS_tvalid(svalid[0]), .S_AXIS_S2MM_STS_tready(sready[0]),
    .S_AXIS_MM2S_STS_tdata(sdata[1]), .S_AXIS_MM2S_STS_tvalid(svalid[1]), .S_AXIS_MM2S_STS_tready(sready[1])
  );

  typedef struct {
    int ch;
    logic [31:0] a;
    logic [22:0] b;
    int rdly;
    int kind;
    bit e_err;
    bit e_to;
  } vec_t;
  vec_t v[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] cmd_of(int t, logic [31:0] a, logic [22:0] b);
    return (72'(t) << 64) | (72'(a) << 32) | (72'(1) << 30) | (72'(1) << 23) | 72'(b);
  endfunction

  function automatic logic [7:0] sts_of(int kind, int t);
    logic [3:0] tg;
    tg = 4'(t);
    case (kind)
      0: return {4'h8, tg};
      1: return {4'h8, tg + 4'd1};
      2: return {1'b1, 3'($urandom_range(1, 7)), tg};
      default: return {1'b0, 3'($urandom_range(0, 7)), tg};
    endcase
  endfunction

  task automatic clear_errs();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("err_cleared", 72'(err), 72'(0));
    chk("timeout_cleared", 72'(tmo), 72'(0));
  endtask

  // kind: 0 ok, 1 wrong tag, 2 error bits, 3 no status (timeout), 4 ok bit clear
  task automatic xfer(int ch, logic [31:0] a, logic [22:0] b, int rdly, int kind, bit clr_sts, bit e_err, bit e_to);
    logic [71:0] exp;
    int k;
    addr[ch] = a;
    btt[ch] = b;
    req[ch] = 1'b1;
    step();
    req[ch] = 1'b0;
    if (b == 23'd0) begin
      chk("zero_done", 72'(done[ch]), 72'(1));
      chk("zero_no_valid", 72'(cvalid[ch]), 72'(0));
      chk("zero_err", 72'(err[ch]), 72'(e_err));
      step();
      chk("zero_done_pulse", 72'(done[ch]), 72'(0));
      return;
    end
    exp = cmd_of(tag_m[ch], a, b);
    chk("cmd_valid", 72'(cvalid[ch]), 72'(1));
    chk("busy", 72'(busy[ch]), 72'(1));
    chk("cmd_data", cdata[ch], exp);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("hold_valid", 72'(cvalid[ch]), 72'(1));
      chk("hold_data", cdata[ch], exp);
    end
    cready[ch] = 1'b1;
    step();
    cready[ch] = 1'b0;
    chk("cmd_drop", 72'(cvalid[ch]), 72'(0));
    chk("sts_ready", 72'(sready[ch]), 72'(1));
    sdata[ch] = sts_of(kind, tag_m[ch]);
    tag_m[ch] = (tag_m[ch] + 1) % 16;
    if (kind == 3) begin
      k = 0;
      while (!done[ch] && k < 40) begin
        step();
        k++;
      end
      chk("timeout_cycles", 72'(k), 72'(16));
    end else begin
      svalid[ch] = 1'b1;
      clr = clr_sts;
      step();
      svalid[ch] = 1'b0;
      clr = 1'b0;
      chk("sts_done", 72'(done[ch]), 72'(1));
    end
    chk("busy_end", 72'(busy[ch]), 72'(0));
    chk("err", 72'(err[ch]), 72'(e_err));
    chk("timeout", 72'(tmo[ch]), 72'(e_to));
    chk("sts_ready_end", 72'(sready[ch]), 72'(0));
    step();
    chk("done_pulse", 72'(done[ch]), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{0, 32'h0000_0100, 23'h400, 0, 0, 1'b0, 1'b0};
    v[1] = '{0, 32'h0000_0200, 23'h010, 0, 0, 1'b0, 1'b0};
    v[2] = '{0, 32'h0000_0300, 23'h020, 0, 1, 1'b1, 1'b0};
    v[3] = '{1, 32'h0000_1000, 23'h800, 2, 2, 1'b1, 1'b0};
    v[4] = '{1, 32'h0000_0040, 23'h001, 10, 0, 1'b0, 1'b0};
    v[5] = '{0, 32'h0000_0005, 23'h000, 0, 0, 1'b1, 1'b0};
    v[6] = '{1, 32'h0000_0080, 23'h7FFFFF, 0, 3, 1'b1, 1'b1};
    v[7] = '{0, 32'hFFFF_FFFC, 23'h004, 1, 4, 1'b1, 1'b0};
    repeat (3) step();
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_err", 72'({err, tmo}), 72'(0));
    chk("rst_valid", 72'(cvalid), 72'(0));
    chk("rst_ready", 72'(sready), 72'(0));
    aresetn = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      clear_errs();
      xfer(v[i].ch, v[i].a, v[i].b, v[i].rdly, v[i].kind, 1'b0, v[i].e_err, v[i].e_to);
    end
    clear_errs();
    xfer(0, 32'h40, 23'h8, 0, 1, 1'b1, 1'b1, 1'b0);
    clear_errs();
    addr[0] = 32'hA0;
    addr[1] = 32'hB0;
    btt[0] = 23'h10;
    btt[1] = 23'h20;
    req = 2'b11;
    step();
    req = 2'b00;
    chk("par_valid", 72'(cvalid), 72'(2'b11));
    chk("par_wr_data", cdata[0], cmd_of(tag_m[0], 32'hA0, 23'h10));
    chk("par_rd_data", cdata[1], cmd_of(tag_m[1], 32'hB0, 23'h20));
    cready = 2'b11;
    step();
    cready = 2'b00;
    chk("par_ready", 72'(sready), 72'(2'b11));
    sdata[0] = sts_of(0, tag_m[0]);
    sdata[1] = sts_of(0, tag_m[1]);
    tag_m[0] = (tag_m[0] + 1) % 16;
    tag_m[1] = (tag_m[1] + 1) % 16;
    svalid = 2'b11;
    step();
    svalid = 2'b00;
    chk("par_done", 72'(done), 72'(2'b11));
    chk("par_err", 72'(err), 72'(0));
    addr[0] = 32'hC0;
    btt[0] = 23'h8;
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    chk("mid_valid", 72'(cvalid[0]), 72'(1));
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    chk("mid_rst_valid", 72'(cvalid[0]), 72'(0));
    chk("mid_rst_done", 72'(done), 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    tag_m = '{0, 0};
    xfer(0, 32'hD0, 23'h18, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef WAVEFORM_DM_LOOP_EN
    clear_errs();
    rd_loop = 1'b1;
    addr[1] = 32'h800;
    btt[1] = 23'h100;
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      chk("loop_valid", 72'(cvalid[1]), 72'(1));
      chk("loop_data", cdata[1], cmd_of(tag_m[1], 32'h800, 23'h100));
      cready[1] = 1'b1;
      step();
      cready[1] = 1'b0;
      if (p == 2) rd_loop = 1'b0;
      sdata[1] = sts_of(0, tag_m[1]);
      tag_m[1] = (tag_m[1] + 1) % 16;
      svalid[1] = 1'b1;
      step();
      svalid[1] = 1'b0;
      chk("loop_done", 72'(done[1]), 72'(1));
    end
    chk("loop_idle", 72'(busy[1]), 72'(0));
    chk("loop_no_valid", 72'(cvalid[1]), 72'(0));
    step();
`endif
    for (int r = 0; r < 30; r++) begin
      int ch, sel, kind;
      logic [22:0] b;
      ch = $urandom_range(0, 1);
      b = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
      sel = $urandom_range(0, 9);
      kind = (sel <= 5) ? 0 : (sel == 6) ? 1 : (sel == 7) ? 2 : (sel == 8) ? 4 : 3;
      clear_errs();
      xfer(ch, $urandom, b, $urandom_range(0, 3), kind, 1'b0,
           (b == 23'd0) || (kind != 0), (b != 23'd0) && (kind == 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
